// File: rtl/dram_rq_arbiter.sv
// dram_rq_arbiter: round-robin share of one DRAM line request port.
// Ports: clk/rst_n; rq_* per-requester slots and returns; m_* downstream.
module dram_rq_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        rq_wstart,
    input  logic [AW*NREQ-1:0]     rq_waddr,
    input  logic [DW*NREQ-1:0]     rq_wdata,
    input  logic [DW/8*NREQ-1:0]   rq_wmask,
    input  logic [NREQ-1:0]        rq_rstart,
    input  logic [AW*NREQ-1:0]     rq_raddr,
    output logic [NREQ-1:0]        rq_finish_wresp,
    output logic [NREQ-1:0]        rq_rdat_valid,
    output logic [DW-1:0]          rq_rdat_data,
    output logic [NREQ-1:0]        rq_finish_mrd,
    output logic [NREQ-1:0]        rq_full,
    output logic [NREQ-1:0]        rq_overflow,
    output logic                   m_wstart_rq,
    output logic [AW-1:0]          m_win_addr,
    output logic [DW-1:0]          m_in_wdata,
    output logic [DW/8-1:0]        m_in_mask,
    input  logic                   m_finish_wresp,
    output logic                   m_rstart_rq,
    output logic [AW-1:0]          m_rin_addr,
    input  logic [DW-1:0]          m_rdat_m_data,
    input  logic                   m_rdat_m_valid,
    input  logic                   m_finish_mrd
);

    localparam int MW = DW / 8;
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE, WISSUE, WWAIT, RISSUE, RWAIT
    } state_t;

    state_t state, state_d;

    logic [NREQ-1:0] wpend, rpend;
    logic [AW-1:0]   wa_s [NREQ];
    logic [DW-1:0]   wd_s [NREQ];
    logic [MW-1:0]   wm_s [NREQ];
    logic [AW-1:0]   ra_s [NREQ];

    // ptr doubles as the owner of the transaction in flight
    logic [PW-1:0]   ptr, gidx, idx;
    logic            gfound, gwrite, grant;
    logic [NREQ-1:0] gsel, wfree, rfree;

    assign rq_full = wpend | rpend;

    // first pending requester after ptr, wrapping
    always_comb begin
        gfound = 1'b0;
        gwrite = 1'b0;
        gidx   = ptr;
        idx    = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!gfound && (wpend[idx] || rpend[idx])) begin
                gfound = 1'b1;
                gidx   = idx;
                gwrite = wpend[idx];
            end
        end
    end

    always_comb begin
        state_d     = state;
        grant       = 1'b0;
        m_wstart_rq = 1'b0;
        m_rstart_rq = 1'b0;
        unique case (state)
            IDLE: begin
                if (gfound) begin
                    grant   = 1'b1;
                    state_d = gwrite ? WISSUE : RISSUE;
                end
            end
            WISSUE: begin
                m_wstart_rq = 1'b1;
                state_d     = WWAIT;
            end
            WWAIT: begin
                if (m_finish_wresp) state_d = IDLE;
            end
            RISSUE: begin
                m_rstart_rq = 1'b1;
                state_d     = RWAIT;
            end
            RWAIT: begin
                if (m_finish_mrd) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gsel  = grant ? (NREQ'(1) << gidx) : '0;
    assign wfree = gwrite ? gsel : '0;
    assign rfree = gwrite ? '0 : gsel;

    // a slot leaving for the issue registers can take a new pulse
    // on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wpend       <= '0;
            rpend       <= '0;
            rq_overflow <= '0;
            for (int i = 0; i < NREQ; i++) begin
                wa_s[i] <= '0;
                wd_s[i] <= '0;
                wm_s[i] <= '0;
                ra_s[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                wpend[i] <= (wpend[i] & ~wfree[i]) | rq_wstart[i];
                rpend[i] <= (rpend[i] & ~rfree[i]) | rq_rstart[i];
                rq_overflow[i] <=
                    (rq_wstart[i] & wpend[i] & ~wfree[i]) |
                    (rq_rstart[i] & rpend[i] & ~rfree[i]);
                if (rq_wstart[i] && (!wpend[i] || wfree[i])) begin
                    wa_s[i] <= rq_waddr[i*AW +: AW];
                    wd_s[i] <= rq_wdata[i*DW +: DW];
                    wm_s[i] <= rq_wmask[i*MW +: MW];
                end
                if (rq_rstart[i] && (!rpend[i] || rfree[i])) begin
                    ra_s[i] <= rq_raddr[i*AW +: AW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= PW'(NREQ - 1);
            m_win_addr      <= '0;
            m_in_wdata      <= '0;
            m_in_mask       <= '0;
            m_rin_addr      <= '0;
            rq_finish_wresp <= '0;
            rq_finish_mrd   <= '0;
            rq_rdat_valid   <= '0;
            rq_rdat_data    <= '0;
        end else begin
            state           <= state_d;
            rq_finish_wresp <= '0;
            rq_finish_mrd   <= '0;
            rq_rdat_valid   <= '0;
            if (grant) begin
                ptr <= gidx;
                if (gwrite) begin
                    m_win_addr <= wa_s[gidx];
                    m_in_wdata <= wd_s[gidx];
                    m_in_mask  <= wm_s[gidx];
                end else begin
                    m_rin_addr <= ra_s[gidx];
                end
            end
            if (state == WWAIT && m_finish_wresp)
                rq_finish_wresp[ptr] <= 1'b1;
            if (state == RWAIT && m_rdat_m_valid) begin
                rq_rdat_valid[ptr] <= 1'b1;
                rq_rdat_data       <= m_rdat_m_data;
            end
            if (state == RWAIT && m_finish_mrd)
                rq_finish_mrd[ptr] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_rq_arbiter.sv
// tb_dram_rq_arbiter: directed + random bench for dram_rq_arbiter.
// Transaction-level model in the bench, compared every cycle.
module tb_dram_rq_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 128;
    localparam int MW   = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      rq_wstart = '0;
    logic [AW*NREQ-1:0]   rq_waddr = '0;
    logic [DW*NREQ-1:0]   rq_wdata = '0;
    logic [MW*NREQ-1:0]   rq_wmask = '0;
    logic [NREQ-1:0]      rq_rstart = '0;
    logic [AW*NREQ-1:0]   rq_raddr = '0;
    logic [NREQ-1:0]      rq_finish_wresp;
    logic [NREQ-1:0]      rq_rdat_valid;
    logic [DW-1:0]        rq_rdat_data;
    logic [NREQ-1:0]      rq_finish_mrd;
    logic [NREQ-1:0]      rq_full;
    logic [NREQ-1:0]      rq_overflow;
    logic                 m_wstart_rq;
    logic [AW-1:0]        m_win_addr;
    logic [DW-1:0]        m_in_wdata;
    logic [MW-1:0]        m_in_mask;
    logic                 m_finish_wresp = 1'b0;
    logic                 m_rstart_rq;
    logic [AW-1:0]        m_rin_addr;
    logic [DW-1:0]        m_rdat_m_data = '0;
    logic                 m_rdat_m_valid = 1'b0;
    logic                 m_finish_mrd = 1'b0;

    dram_rq_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_wstart(rq_wstart), .rq_waddr(rq_waddr),
        .rq_wdata(rq_wdata), .rq_wmask(rq_wmask),
        .rq_rstart(rq_rstart), .rq_raddr(rq_raddr),
        .rq_finish_wresp(rq_finish_wresp),
        .rq_rdat_valid(rq_rdat_valid),
        .rq_rdat_data(rq_rdat_data),
        .rq_finish_mrd(rq_finish_mrd),
        .rq_full(rq_full), .rq_overflow(rq_overflow),
        .m_wstart_rq(m_wstart_rq), .m_win_addr(m_win_addr),
        .m_in_wdata(m_in_wdata), .m_in_mask(m_in_mask),
        .m_finish_wresp(m_finish_wresp),
        .m_rstart_rq(m_rstart_rq), .m_rin_addr(m_rin_addr),
        .m_rdat_m_data(m_rdat_m_data),
        .m_rdat_m_valid(m_rdat_m_valid),
        .m_finish_mrd(m_finish_mrd)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- reference model ----------------
    // slots, plus one in-flight transaction: announced (start
    // pulse shows next cycle) or waiting for its completion.
    logic [NREQ-1:0] mwp, mrp;
    logic [AW-1:0]   mwa [NREQ];
    logic [DW-1:0]   mwd [NREQ];
    logic [MW-1:0]   mwm [NREQ];
    logic [AW-1:0]   mra [NREQ];
    int              mptr, own;
    bit              txn, issuing, tw;
    logic            e_ws, e_rs;
    logic [AW-1:0]   e_wa, e_ra;
    logic [DW-1:0]   e_wd, e_rd;
    logic [MW-1:0]   e_wm;
    logic [NREQ-1:0] e_fw, e_fr, e_rv, e_ovf;

    task automatic model_reset();
        mwp = '0; mrp = '0;
        for (int i = 0; i < NREQ; i++) begin
            mwa[i] = '0; mwd[i] = '0; mwm[i] = '0; mra[i] = '0;
        end
        mptr = NREQ - 1; own = 0;
        txn = 0; issuing = 0; tw = 0;
        e_ws = 0; e_rs = 0; e_wa = '0; e_ra = '0;
        e_wd = '0; e_rd = '0; e_wm = '0;
        e_fw = '0; e_fr = '0; e_rv = '0; e_ovf = '0;
    endtask

    task automatic model_step();
        int j;
        e_fw = '0; e_fr = '0; e_rv = '0; e_ovf = '0;
        if (txn && !issuing) begin
            if (tw) begin
                if (m_finish_wresp) begin e_fw[own] = 1'b1; txn = 0; end
            end else begin
                if (m_rdat_m_valid) begin
                    e_rv[own] = 1'b1;
                    e_rd = m_rdat_m_data;
                end
                if (m_finish_mrd) begin e_fr[own] = 1'b1; txn = 0; end
            end
        end else if (txn) begin
            issuing = 0;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (mptr + k) % NREQ;
                if (!txn && (mwp[j] || mrp[j])) begin
                    txn = 1; issuing = 1; own = j; mptr = j;
                    tw = mwp[j];
                    if (tw) begin
                        e_wa = mwa[j]; e_wd = mwd[j]; e_wm = mwm[j];
                        mwp[j] = 1'b0;
                    end else begin
                        e_ra = mra[j];
                        mrp[j] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rq_wstart[i]) begin
                if (mwp[i]) e_ovf[i] = 1'b1;
                else begin
                    mwp[i] = 1'b1;
                    mwa[i] = rq_waddr[i*AW +: AW];
                    mwd[i] = rq_wdata[i*DW +: DW];
                    mwm[i] = rq_wmask[i*MW +: MW];
                end
            end
            if (rq_rstart[i]) begin
                if (mrp[i]) e_ovf[i] = 1'b1;
                else begin
                    mrp[i] = 1'b1;
                    mra[i] = rq_raddr[i*AW +: AW];
                end
            end
        end
        e_ws = txn && issuing && tw;
        e_rs = txn && issuing && !tw;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("m_wstart_rq", DW'(m_wstart_rq), DW'(e_ws));
            chk("m_rstart_rq", DW'(m_rstart_rq), DW'(e_rs));
            chk("m_win_addr", DW'(m_win_addr), DW'(e_wa));
            chk("m_in_wdata", m_in_wdata, e_wd);
            chk("m_in_mask", DW'(m_in_mask), DW'(e_wm));
            chk("m_rin_addr", DW'(m_rin_addr), DW'(e_ra));
            chk("rq_finish_wresp", DW'(rq_finish_wresp), DW'(e_fw));
            chk("rq_finish_mrd", DW'(rq_finish_mrd), DW'(e_fr));
            chk("rq_rdat_valid", DW'(rq_rdat_valid), DW'(e_rv));
            chk("rq_rdat_data", rq_rdat_data, e_rd);
            chk("rq_full", DW'(rq_full), DW'(mwp | mrp));
            chk("rq_overflow", DW'(rq_overflow), DW'(e_ovf));
        end
    end

    // ---------------- downstream responder ----------------
    int rjob = 0, rdly = 0, rbeats = 0;

    task automatic respond(input bit spur);
        m_finish_wresp = 1'b0;
        m_finish_mrd   = 1'b0;
        m_rdat_m_valid = 1'b0;
        m_rdat_m_data  = rnd128();
        if (rjob == 0) begin
            if (m_wstart_rq) begin
                rjob = 1; rdly = $urandom_range(0, 3);
            end else if (m_rstart_rq) begin
                rjob = 2; rdly = $urandom_range(0, 3);
                rbeats = $urandom_range(0, 3);
            end else if (spur && $urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0: m_finish_wresp = 1'b1;
                    1: m_finish_mrd = 1'b1;
                    default: m_rdat_m_valid = 1'b1;
                endcase
            end
        end else if (rdly > 0) begin
            rdly--;
        end else if (rjob == 1) begin
            m_finish_wresp = 1'b1; rjob = 0;
        end else if (rbeats > 0) begin
            m_rdat_m_valid = 1'b1; rbeats--;
            rdly = $urandom_range(0, 1);
        end else begin
            m_finish_mrd = 1'b1; rjob = 0;
        end
    endtask

    // waits for one issue, completes it, reports kind and owner
    task automatic serve(output bit isw, output logic [NREQ-1:0] who);
        int n = 0;
        isw = 0; who = '0;
        while (!m_wstart_rq && !m_rstart_rq && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL serve_timeout no start within 20 cycles");
            return;
        end
        isw = m_wstart_rq;
        @(negedge clk);
        if (isw) m_finish_wresp = 1'b1;
        else m_finish_mrd = 1'b1;
        @(negedge clk);
        m_finish_wresp = 1'b0;
        m_finish_mrd   = 1'b0;
        who = isw ? rq_finish_wresp : rq_finish_mrd;
    endtask

    localparam logic [DW-1:0] DA = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [DW-1:0] DR = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

    initial begin
        bit isw;
        logic [NREQ-1:0] who;
        int n;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_full", DW'(rq_full), '0);
        chk("rst_wstart", DW'(m_wstart_rq), '0);
        chk("rst_waddr", DW'(m_win_addr), '0);

        // single write from requester 0
        @(negedge clk);
        rq_wstart = 3'b001;
        rq_waddr[0 +: AW] = 32'h0000_1000;
        rq_wdata[0 +: DW] = DA;
        rq_wmask[0 +: MW] = 16'hffff;
        @(negedge clk);
        rq_wstart = '0;
        chk("w0_full", DW'(rq_full), DW'(3'b001));
        chk("w0_early", DW'(m_wstart_rq), '0);
        @(negedge clk);
        chk("w0_start", DW'(m_wstart_rq), DW'(1'b1));
        chk("w0_addr", DW'(m_win_addr), DW'(32'h1000));
        chk("w0_data", m_in_wdata, DA);
        chk("w0_mask", DW'(m_in_mask), DW'(16'hffff));
        @(negedge clk);
        chk("w0_start_once", DW'(m_wstart_rq), '0);
        m_finish_wresp = 1'b1;
        @(negedge clk);
        m_finish_wresp = 1'b0;
        chk("w0_fin", DW'(rq_finish_wresp), DW'(3'b001));
        chk("w0_free", DW'(rq_full), '0);

        // single read from requester 1 with one data beat
        @(negedge clk);
        rq_rstart = 3'b010;
        rq_raddr[AW +: AW] = 32'h0000_2000;
        @(negedge clk);
        rq_rstart = '0;
        @(negedge clk);
        chk("r1_start", DW'(m_rstart_rq), DW'(1'b1));
        chk("r1_addr", DW'(m_rin_addr), DW'(32'h2000));
        @(negedge clk);
        m_rdat_m_valid = 1'b1;
        m_rdat_m_data  = DR;
        @(negedge clk);
        m_rdat_m_valid = 1'b0;
        chk("r1_valid", DW'(rq_rdat_valid), DW'(3'b010));
        chk("r1_data", rq_rdat_data, DR);
        m_finish_mrd = 1'b1;
        @(negedge clk);
        m_finish_mrd = 1'b0;
        chk("r1_fin", DW'(rq_finish_mrd), DW'(3'b010));
        chk("r1_valid_off", DW'(rq_rdat_valid), '0);

        // overflow while busy, then capture on the grant edge
        @(negedge clk);
        rq_wstart = 3'b010;
        rq_waddr[AW +: AW] = 32'h3000;
        rq_wdata[DW +: DW] = rnd128();
        @(negedge clk);
        rq_wstart = 3'b001;
        rq_waddr[0 +: AW] = 32'h4000;
        rq_wdata[0 +: DW] = 128'haaaa;
        @(negedge clk);
        chk("ov_busy_start", DW'(m_wstart_rq), DW'(1'b1));
        chk("ov_busy_addr", DW'(m_win_addr), DW'(32'h3000));
        rq_waddr[0 +: AW] = 32'h5000;
        rq_wdata[0 +: DW] = 128'hbbbb;
        @(negedge clk);
        rq_wstart = '0;
        chk("ov_pulse", DW'(rq_overflow), DW'(3'b001));
        m_finish_wresp = 1'b1;
        @(negedge clk);
        m_finish_wresp = 1'b0;
        chk("ov_fin1", DW'(rq_finish_wresp), DW'(3'b010));
        rq_wstart = 3'b001;
        rq_waddr[0 +: AW] = 32'h6000;
        rq_wdata[0 +: DW] = 128'hcccc;
        @(negedge clk);
        rq_wstart = '0;
        chk("ov_orig_addr", DW'(m_win_addr), DW'(32'h4000));
        chk("ov_orig_data", m_in_wdata, 128'haaaa);
        chk("same_edge_no_ovf", DW'(rq_overflow), '0);
        chk("same_edge_full", DW'(rq_full), DW'(3'b001));
        serve(isw, who);
        chk("ov_fin0", DW'(who), DW'(3'b001));
        serve(isw, who);
        chk("cap_addr", DW'(m_win_addr), DW'(32'h6000));
        chk("cap_data", m_in_wdata, 128'hcccc);
        chk("cap_fin", DW'(who), DW'(3'b001));

        // reset while waiting on a write
        @(negedge clk);
        rq_wstart = 3'b001;
        @(negedge clk);
        rq_wstart = '0;
        @(negedge clk);
        chk("rw_start", DW'(m_wstart_rq), DW'(1'b1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_full", DW'(rq_full), '0);
        chk("rw_waddr", DW'(m_win_addr), '0);
        chk("rw_wdata", m_in_wdata, '0);
        chk("rw_rdata", rq_rdat_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_finish_wresp = 1'b1;
        @(negedge clk);
        m_finish_wresp = 1'b0;
        chk("rw_late_fin", DW'(rq_finish_wresp), '0);

        // round robin after reset: 0,1,2 twice
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            rq_rstart = 3'b111;
            @(negedge clk);
            rq_rstart = '0;
            for (int g = 0; g < NREQ; g++) begin
                serve(isw, who);
                chk("rr_kind", DW'(isw), '0);
                chk("rr_order", DW'(who), DW'(3'b001 << g));
            end
        end

        // write and read from requester 2 in one cycle
        @(negedge clk);
        rq_wstart = 3'b100;
        rq_rstart = 3'b100;
        @(negedge clk);
        rq_wstart = '0;
        rq_rstart = '0;
        serve(isw, who);
        chk("wr_first_kind", DW'(isw), DW'(1'b1));
        chk("wr_first_who", DW'(who), DW'(3'b100));
        serve(isw, who);
        chk("wr_second_kind", DW'(isw), '0);
        chk("wr_second_who", DW'(who), DW'(3'b100));

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            respond(1'b1);
            for (int i = 0; i < NREQ; i++) begin
                rq_wstart[i] = ($urandom_range(0, 5) == 0);
                rq_rstart[i] = ($urandom_range(0, 5) == 0);
                rq_waddr[i*AW +: AW] = $urandom;
                rq_wdata[i*DW +: DW] = rnd128();
                rq_wmask[i*MW +: MW] = MW'($urandom);
                rq_raddr[i*AW +: AW] = $urandom;
            end
        end
        @(negedge clk);
        rq_wstart = '0;
        rq_rstart = '0;
        respond(1'b0);
        n = 0;
        while (n < 400 && (rq_full != '0 || rjob != 0 ||
                           m_wstart_rq || m_rstart_rq)) begin
            @(negedge clk);
            respond(1'b0);
            n++;
        end
        chk("drain_full", DW'(rq_full), '0);
        chk("drain_job", DW'(rjob), '0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
